axi_write_scheduler: RTL and testbench

- Controller that sequences the shared AXI write path (AW/W/B) between two masters (M0, M1) and three slave ports (S0, S1, default slave).
- Arbitrates AW requests round-robin, decodes the target slave, and locks routing until the write response completes.
- Drives only select/steering signals. The AW/W/B multiplexers and the default slave are separate blocks that consume these selects.
- One transaction in flight at a time.

---
 rtl/axi_write_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_axi_write_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : axi_write_scheduler
// Purpose  : Sequences the shared AXI write path (AW -> W -> B) between two
//            masters (M0, M1) and three slave ports (S0, S1, default slave).
//            AW requests are arbitrated round-robin in IDLE. The winner and
//            its decoded slave are latched, and routing stays locked until
//            the write response handshake completes. Only one transaction is
//            in flight at a time. This block drives selects only; the muxes
//            and the default slave live elsewhere.
// Ports    : clk        - clock, all state on rising edge
//            rst        - synchronous reset, active low
//            awvalid_m  - AWVALID of {M1,M0}
//            awaddr_m0  - AWADDR of M0
//            awaddr_m1  - AWADDR of M1
//            aw_hs      - AW handshake seen at the selected slave port
//            w_hs       - W handshake seen on the routed W path
//            wlast      - WLAST of the routed W beat
//            b_hs       - B handshake seen on the routed B path
//            aw_grant   - one-hot AW master select {M1,M0}
//            aw_slave   - one-hot AW slave steer {DEF,S1,S0}
//            w_master   - one-hot W master select {M1,M0}
//            w_slave    - one-hot W slave steer {DEF,S1,S0}
//            b_master   - one-hot B return select {M1,M0}
//            b_slave    - one-hot B source select {DEF,S1,S0}
//            busy       - high whenever the scheduler is not idle
// Revision : 1.0 - initial release
// ============================================================================
module axi_write_scheduler #(
  parameter logic [15:0] S0_BASE = 16'h0000,
  parameter logic [15:0] S1_BASE = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  awvalid_m,
  input  logic [31:0] awaddr_m0,
  input  logic [31:0] awaddr_m1,
  input  logic        aw_hs,
  input  logic        w_hs,
  input  logic        wlast,
  input  logic        b_hs,
  output logic [1:0]  aw_grant,
  output logic [2:0]  aw_slave,
  output logic [1:0]  w_master,
  output logic [2:0]  w_slave,
  output logic [1:0]  b_master,
  output logic [2:0]  b_slave,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [1:0] M0_OH  = 2'b01;
  localparam logic [1:0] M1_OH  = 2'b10;
  localparam logic [2:0] S0_OH  = 3'b001;
  localparam logic [2:0] S1_OH  = 3'b010;
  localparam logic [2:0] DEF_OH = 3'b100;

  state_e      state_q, state_d;
  logic        rr_q, rr_d;     // 0: M0 wins a tie, 1: M1 wins a tie
  logic [1:0]  mst_q, mst_d;   // latched one-hot master
  logic [2:0]  slv_q, slv_d;   // latched one-hot slave

  logic [1:0]  win_oh;
  logic [15:0] win_addr_hi;
  logic [2:0]  win_slv;

  // Only the upper address half takes part in decoding.
  logic unused_addr_lo;
  assign unused_addr_lo = ^{awaddr_m0[15:0], awaddr_m1[15:0]};

  // --------------------------------------------------------------------------
  // Arbitration and decode (consumed only in IDLE)
  // --------------------------------------------------------------------------
  always_comb begin
    win_oh = awvalid_m;
    if (awvalid_m == 2'b11) begin
      win_oh = rr_q ? M1_OH : M0_OH;
    end

    win_addr_hi = win_oh[1] ? awaddr_m1[31:16] : awaddr_m0[31:16];

    // S0 takes precedence if both bases were ever configured equal.
    if (win_addr_hi == S0_BASE) begin
      win_slv = S0_OH;
    end else if (win_addr_hi == S1_BASE) begin
      win_slv = S1_OH;
    end else begin
      win_slv = DEF_OH;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    mst_d   = mst_q;
    slv_d   = slv_q;

    case (state_q)
      ST_IDLE: begin
        if (awvalid_m != 2'b00) begin
          mst_d   = win_oh;
          slv_d   = win_slv;
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (aw_hs) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        // Burst length is not counted; WLAST on a real beat ends the burst.
        if (w_hs && wlast) begin
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        if (b_hs) begin
          state_d = ST_IDLE;
          // Hand tie priority to the master that was not just served.
          rr_d    = mst_q[0];
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      mst_q   <= 2'b00;
      slv_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      mst_q   <= mst_d;
      slv_q   <= slv_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded purely from registered state so that no input can
  // glitch a select, and only one phase group is ever active.
  // --------------------------------------------------------------------------
  always_comb begin
    aw_grant = 2'b00;
    aw_slave = 3'b000;
    w_master = 2'b00;
    w_slave  = 3'b000;
    b_master = 2'b00;
    b_slave  = 3'b000;
    busy     = (state_q != ST_IDLE);

    case (state_q)
      ST_ADDR: begin
        aw_grant = mst_q;
        aw_slave = slv_q;
      end
      ST_DATA: begin
        w_master = mst_q;
        w_slave  = slv_q;
      end
      ST_RESP: begin
        b_master = mst_q;
        b_slave  = slv_q;
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Structural properties of the select outputs
  // --------------------------------------------------------------------------
  a_aw_onehot : assert property (@(posedge clk) disable iff (!rst)
    $onehot0(aw_grant) && $onehot0(aw_slave));
  a_w_onehot : assert property (@(posedge clk) disable iff (!rst)
    $onehot0(w_master) && $onehot0(w_slave));
  a_b_onehot : assert property (@(posedge clk) disable iff (!rst)
    $onehot0(b_master) && $onehot0(b_slave));
  a_exclusive : assert property (@(posedge clk) disable iff (!rst)
    $onehot0({|aw_grant, |w_master, |b_master}));

endmodule
`default_nettype wire

// File: tb/tb_axi_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_write_scheduler
// Purpose  : Self-checking bench for axi_write_scheduler. Each issued request
//            pushes its expected {master, slave} onto a scoreboard queue;
//            a negedge monitor pops it when the AW grant rises. Phase-by-phase
//            checks run inside the transaction task.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_write_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  awvalid_m;
  logic [31:0] awaddr_m0;
  logic [31:0] awaddr_m1;
  logic        aw_hs;
  logic        w_hs;
  logic        wlast;
  logic        b_hs;
  logic [1:0]  aw_grant;
  logic [2:0]  aw_slave;
  logic [1:0]  w_master;
  logic [2:0]  w_slave;
  logic [1:0]  b_master;
  logic [2:0]  b_slave;
  logic        busy;

  always #5 clk = ~clk;

  axi_write_scheduler #(
    .S0_BASE(16'h0000),
    .S1_BASE(16'h0001)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .awvalid_m(awvalid_m),
    .awaddr_m0(awaddr_m0),
    .awaddr_m1(awaddr_m1),
    .aw_hs    (aw_hs),
    .w_hs     (w_hs),
    .wlast    (wlast),
    .b_hs     (b_hs),
    .aw_grant (aw_grant),
    .aw_slave (aw_slave),
    .w_master (w_master),
    .w_slave  (w_slave),
    .b_master (b_master),
    .b_slave  (b_slave),
    .busy     (busy)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0] m;
    logic [2:0] s;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    awvalid_m = 2'b00;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    wlast     = 1'b0;
    b_hs      = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_aw"},   {27'd0, aw_grant, aw_slave}, 32'd0);
    chk({tag, "_w"},    {27'd0, w_master, w_slave},  32'd0);
    chk({tag, "_b"},    {27'd0, b_master, b_slave},  32'd0);
    chk({tag, "_busy"}, {31'd0, busy},               32'd0);
  endtask

  // Monitor: scoreboard pop on grant rise plus group exclusivity each cycle.
  logic [1:0] prev_aw = 2'b00;
  always @(negedge clk) begin
    exp_t e;
    int   ng;
    if (rst === 1'b1) begin
      ng = int'(aw_grant != 0) + int'(w_master != 0) + int'(b_master != 0);
      chk("excl", {31'd0, ng <= 1}, 32'd1);
      chk("onehot", {31'd0, $onehot0(aw_grant) && $onehot0(aw_slave) &&
                            $onehot0(w_master) && $onehot0(w_slave) &&
                            $onehot0(b_master) && $onehot0(b_slave)}, 32'd1);
      if (aw_grant != 2'b00 && prev_aw == 2'b00) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_grant", {30'd0, aw_grant}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_grant", {30'd0, aw_grant}, {30'd0, e.m});
          chk("sb_slave", {29'd0, aw_slave}, {29'd0, e.s});
        end
      end
    end
    prev_aw = aw_grant;
  end

  // One complete write. Called in an IDLE cycle just after a rising edge;
  // returns in the IDLE cycle following the B handshake.
  task automatic run_txn(input logic [1:0] vld, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [1:0] em, input logic [2:0] es,
                         input int aw_wait, input int beats, input int stall,
                         input int b_wait, input bit hold, input bit spur);
    exp_t e;
    e.m = em;
    e.s = es;
    sb.push_back(e);
    awvalid_m = vld;
    awaddr_m0 = a0;
    awaddr_m1 = a1;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    tick();
    // ADDR
    chk("aw_grant", {30'd0, aw_grant}, {30'd0, em});
    chk("aw_slave", {29'd0, aw_slave}, {29'd0, es});
    chk("addr_busy", {31'd0, busy}, 32'd1);
    if (!hold) awvalid_m = 2'b00;
    if (spur) begin
      w_hs      = 1'b1;
      wlast     = 1'b1;
      b_hs      = 1'b1;
      awaddr_m0 = 32'h3000_0000;
      awaddr_m1 = 32'h3000_0000;
    end
    for (int i = 0; i < aw_wait; i++) begin
      tick();
      w_hs  = 1'b0;
      wlast = 1'b0;
      b_hs  = 1'b0;
      chk("aw_hold_grant", {30'd0, aw_grant}, {30'd0, em});
      chk("aw_hold_slave", {29'd0, aw_slave}, {29'd0, es});
      chk("addr_w_zero", {27'd0, w_master, w_slave}, 32'd0);
      chk("addr_b_zero", {27'd0, b_master, b_slave}, 32'd0);
    end
    aw_hs = 1'b1;
    tick();
    aw_hs = 1'b0;
    // DATA
    chk("w_master", {30'd0, w_master}, {30'd0, em});
    chk("w_slave", {29'd0, w_slave}, {29'd0, es});
    chk("aw_drop", {27'd0, aw_grant, aw_slave}, 32'd0);
    for (int b = 1; b <= beats; b++) begin
      for (int s = 0; s < stall; s++) begin
        wlast = 1'b1;  // stray WLAST without a handshake
        tick();
        wlast = 1'b0;
        chk("w_stall", {30'd0, w_master}, {30'd0, em});
      end
      w_hs  = 1'b1;
      wlast = (b == beats);
      tick();
      w_hs  = 1'b0;
      wlast = 1'b0;
      if (b < beats) begin
        chk("w_stay", {30'd0, w_master}, {30'd0, em});
        chk("w_no_b", {30'd0, b_master}, 32'd0);
      end
    end
    // RESP
    chk("b_master", {30'd0, b_master}, {30'd0, em});
    chk("b_slave", {29'd0, b_slave}, {29'd0, es});
    chk("w_drop", {27'd0, w_master, w_slave}, 32'd0);
    for (int i = 0; i < b_wait; i++) begin
      tick();
      chk("b_hold", {30'd0, b_master}, {30'd0, em});
    end
    b_hs = 1'b1;
    tick();
    b_hs = 1'b0;
    check_all_zero("done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    quiet_inputs();
    awaddr_m0 = 32'h0;
    awaddr_m1 = 32'h0;
    rst = 1'b0;
    tick();
    tick();
    check_all_zero("rst");
    rst = 1'b1;

    // Spurious W/B handshakes in IDLE change nothing.
    w_hs = 1'b1; wlast = 1'b1; b_hs = 1'b1;
    tick();
    quiet_inputs();
    check_all_zero("spur_idle");

    // Single write M0 -> S0 with the documented cycle timing.
    run_txn(2'b01, 32'h0000_0040, 32'h0, 2'b01, 3'b001, 2, 1, 2, 1, 1'b0, 1'b0);

    // Round-robin contention from reset, both masters held valid.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    run_txn(2'b11, 32'h0001_0000, 32'h0000_0010, 2'b01, 3'b010, 0, 1, 0, 0, 1'b1, 1'b0);
    run_txn(2'b11, 32'h0001_0000, 32'h0000_0010, 2'b10, 3'b001, 0, 1, 0, 0, 1'b1, 1'b0);
    run_txn(2'b11, 32'h0001_0000, 32'h0000_0010, 2'b01, 3'b010, 0, 1, 0, 0, 1'b1, 1'b0);
    run_txn(2'b11, 32'h0001_0000, 32'h0000_0010, 2'b10, 3'b001, 0, 1, 0, 0, 1'b1, 1'b0);
    quiet_inputs();

    // M0 alone (tie priority moves to M1), then a decode error from M1
    // (priority back to M0), then a tie must go to M0.
    run_txn(2'b01, 32'h0000_0000, 32'h0, 2'b01, 3'b001, 0, 1, 0, 0, 1'b0, 1'b0);
    run_txn(2'b10, 32'h0, 32'h2000_0000, 2'b10, 3'b100, 1, 2, 0, 1, 1'b0, 1'b0);
    run_txn(2'b11, 32'h0000_0040, 32'h2000_0000, 2'b01, 3'b001, 0, 1, 0, 0, 1'b0, 1'b0);

    // 4-beat burst with stalls and stray WLAST; spurious inputs and an
    // address change while in ADDR.
    run_txn(2'b01, 32'h0001_0004, 32'h0, 2'b01, 3'b010, 2, 4, 1, 0, 1'b0, 1'b1);

    // Reset during DATA aborts the transaction; tie priority returns to M0.
    e.m = 2'b10;
    e.s = 3'b001;
    sb.push_back(e);
    awvalid_m = 2'b10;
    awaddr_m1 = 32'h0000_0100;
    tick();
    awvalid_m = 2'b00;
    aw_hs = 1'b1;
    tick();
    aw_hs = 1'b0;
    chk("mid_w_master", {30'd0, w_master}, 32'd2);
    rst = 1'b0;
    tick();
    check_all_zero("mid_rst");
    rst = 1'b1;
    tick();
    check_all_zero("post_rst");
    run_txn(2'b11, 32'h0000_0008, 32'h0001_0008, 2'b01, 3'b001, 0, 1, 0, 0, 1'b0, 1'b0);

    tick();
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
